// File: rtl/pe_tmr_bist_ctrl.sv
`timescale 1ns/1ps
// BIST sequencer for one TMR PE: a golden pass, then a stuck-at pass per MAC polarity, each MISR-compacted.
// Optional BIST_DOUBLE_FAULT_EN adds phase 7 (MAC0+MAC1 SA1), which must differ from golden.
module pe_tmr_bist_ctrl #(
  parameter int                     WORD_SIZE   = 16,
  parameter int                     NUM_VECTORS = 32,
  parameter int                     PE_LAT      = 2,
  parameter logic [15:0]            LFSR_SEED   = 16'hACE1,
  parameter logic [2*WORD_SIZE-1:0] MISR_POLY   = (2*WORD_SIZE)'(32'h04C1_1DB7)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] pe_right_in,
  input  logic [WORD_SIZE-1:0] pe_bottom_in,
  output logic [WORD_SIZE-1:0] left_out,
  output logic [WORD_SIZE-1:0] top_out,
  output logic                 fsm_op2_sel,
  output logic                 fsm_out_sel,
  output logic                 stat_bit,
  output logic [5:0]           fault_inject,
  output logic                 pe_clr,
  output logic                 test_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2:0]           fail_phase,
  output logic [2:0]           fail_cnt
);
  localparam int MW = 2*WORD_SIZE;
  localparam int CW = $clog2((NUM_VECTORS > PE_LAT ? NUM_VECTORS : PE_LAT) + 1);
`ifdef BIST_DOUBLE_FAULT_EN
  localparam logic [2:0] LAST_PHASE = 3'd7;
`else
  localparam logic [2:0] LAST_PHASE = 3'd6;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_APPLY, S_DRAIN, S_CMP, S_FIN} state_e;
  state_e state, state_nxt;

  logic [2:0]    phase;
  logic [CW-1:0] cnt;
  logic [15:0]   lfsr, lfsr_nxt, lfsr_rev;
  logic [MW-1:0] misr, misr_nxt, golden;
  logic [5:0]    fi_phase;
  logic          phase_fail;

  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign misr_nxt = {misr[MW-2:0], misr[MW-1]} ^ {pe_bottom_in, pe_right_in}
                  ^ (misr[MW-1] ? MISR_POLY : '0);

  always_comb begin
    lfsr_rev = '0;
    for (int i = 0; i < 16; i++) lfsr_rev[i] = lfsr[15-i];
  end

  always_comb begin
    case (phase)
      3'd1:    fi_phase = 6'h01;
      3'd2:    fi_phase = 6'h03;
      3'd3:    fi_phase = 6'h04;
      3'd4:    fi_phase = 6'h0C;
      3'd5:    fi_phase = 6'h10;
      3'd6:    fi_phase = 6'h30;
`ifdef BIST_DOUBLE_FAULT_EN
      3'd7:    fi_phase = 6'h0F;
`endif
      default: fi_phase = 6'h00;
    endcase
  end

  // Double-fault phase is inverted: matching golden means the voter was never exercised.
  always_comb begin
    phase_fail = (phase != 3'd0) && (misr != golden);
`ifdef BIST_DOUBLE_FAULT_EN
    if (phase == 3'd7) phase_fail = (misr == golden);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_APPLY;
      S_APPLY: if (cnt == CW'(NUM_VECTORS-1)) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt == CW'(PE_LAT-1)) state_nxt = S_CMP;
      S_CMP:   state_nxt = (phase == LAST_PHASE) ? S_FIN : S_SETUP;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    test_mode    = 1'b0;
    done         = 1'b0;
    pe_clr       = 1'b0;
    fault_inject = 6'h00;
    left_out     = '0;
    top_out      = '0;
    case (state)
      S_SETUP, S_APPLY, S_DRAIN, S_CMP: begin
        busy         = 1'b1;
        test_mode    = 1'b1;
        fault_inject = fi_phase;
        pe_clr       = (state == S_SETUP);
        if (state == S_APPLY) begin
          left_out = WORD_SIZE'(lfsr);
          top_out  = WORD_SIZE'(lfsr_rev);
        end
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign fsm_op2_sel = 1'b0;
  assign fsm_out_sel = 1'b0;
  assign stat_bit    = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase      <= '0;
      cnt        <= '0;
      lfsr       <= LFSR_SEED;
      misr       <= '0;
      golden     <= '0;
      fail_cnt   <= '0;
      fail_phase <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          phase      <= '0;
          fail_cnt   <= '0;
          fail_phase <= '0;
          pass       <= 1'b0;
        end
        S_SETUP: begin
          lfsr <= LFSR_SEED;
          misr <= '0;
          cnt  <= '0;
        end
        S_APPLY: begin
          lfsr <= lfsr_nxt;
          misr <= misr_nxt;
          cnt  <= (cnt == CW'(NUM_VECTORS-1)) ? '0 : cnt + CW'(1);
        end
        S_DRAIN: begin
          misr <= misr_nxt;
          cnt  <= cnt + CW'(1);
        end
        S_CMP: begin
          if (phase == 3'd0) golden <= misr;
          if (phase_fail) begin
            if (fail_cnt != 3'd7)   fail_cnt   <= fail_cnt + 3'd1;
            if (fail_phase == 3'd0) fail_phase <= phase;
          end
          if (phase == LAST_PHASE) pass <= (fail_cnt == 3'd0) && !phase_fail;
          else                     phase <= phase + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_tmr_bist_ctrl.sv
`timescale 1ns/1ps
// Bench for pe_tmr_bist_ctrl: a TMR PE model drives the DUT; a cycle-offset reference model
// derives every expected output and the per-phase signatures from the stimulus.
module tb_pe_tmr_bist_ctrl;
  localparam int W    = 16;
  localparam int NV   = 32;
  localparam int PLT  = 2;
  localparam int PLEN = NV + PLT + 2;
`ifdef BIST_DOUBLE_FAULT_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 7;
`endif
  localparam int FIN_K   = NPH*PLEN + 1;
  localparam int EXP_LAT = (NPH == 8) ? 289 : 253;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] pe_right_in, pe_bottom_in, left_out, top_out;
  logic fsm_op2_sel, fsm_out_sel, stat_bit, pe_clr, test_mode, busy, done, pass;
  logic [5:0] fault_inject;
  logic [2:0] fail_phase, fail_cnt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pe_tmr_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .pe_right_in(pe_right_in), .pe_bottom_in(pe_bottom_in),
    .left_out(left_out), .top_out(top_out),
    .fsm_op2_sel(fsm_op2_sel), .fsm_out_sel(fsm_out_sel), .stat_bit(stat_bit),
    .fault_inject(fault_inject), .pe_clr(pe_clr), .test_mode(test_mode),
    .busy(busy), .done(done), .pass(pass),
    .fail_phase(fail_phase), .fail_cnt(fail_cnt)
  );

  // ---------------- TMR PE model ----------------
  typedef enum int {PE_OK, PE_MAC0, PE_RZERO, PE_MAC2} pe_mode_e;
  pe_mode_e pe_mode = PE_OK;
  logic [W-1:0] acc [3] = '{default: '0};
  logic [W-1:0] left_d = '0;
  logic [W-1:0] mb [3], mr [3];

  always @(posedge clk) begin
    left_d <= left_out ^ top_out;
    for (int m = 0; m < 3; m++) acc[m] <= pe_clr ? '0 : acc[m] + left_out * top_out;
  end

  always_comb begin
    for (int m = 0; m < 3; m++) begin
      mb[m] = acc[m];
      mr[m] = acc[m] ^ left_d;
      if (fault_inject[2*m]) begin
        mb[m] = {W{fault_inject[2*m+1]}};
        mr[m] = {W{fault_inject[2*m+1]}};
      end
    end
    case (pe_mode)
      PE_MAC0: begin pe_bottom_in = mb[0]; pe_right_in = mr[0]; end
      PE_MAC2: begin pe_bottom_in = mb[2]; pe_right_in = mr[2]; end
      default: begin
        pe_bottom_in = (mb[0] & mb[1]) | (mb[0] & mb[2]) | (mb[1] & mb[2]);
        pe_right_in  = (mr[0] & mr[1]) | (mr[0] & mr[2]) | (mr[1] & mr[2]);
      end
    endcase
    if (pe_mode == PE_RZERO) pe_right_in = '0;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [5:0] fi_of(input int p);
    logic [5:0] v = '0;
    if (p == 7) return 6'h0F;
    if (p > 0) begin
      v[2*((p-1)/2)]   = 1'b1;
      v[2*((p-1)/2)+1] = ((p-1) % 2) == 1;
    end
    return v;
  endfunction

  // ---------------- reference model + compare ----------------
  logic [15:0] lfsr_seq [NV];
  logic [5:0]  fi_seen [8];
  logic [W-1:0] cap_l0, cap_l1, cap_t0;

  initial begin : model
    int k, ph, pos;
    logic [31:0] misr_m, golden_m;
    logic [2:0]  e_fcnt, e_fph;
    logic        e_pass, e_busy, e_done, e_clr, bad;
    logic [5:0]  e_fi;
    logic [15:0] e_vec, s;
    s = 16'hACE1;
    for (int i = 0; i < NV; i++) begin
      lfsr_seq[i] = s;
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end
    k = 0; misr_m = '0; golden_m = '0; e_fcnt = '0; e_fph = '0; e_pass = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        k = 0; e_fcnt = '0; e_fph = '0; e_pass = 1'b0;
      end
      e_busy = 1'b0; e_done = 1'b0; e_clr = 1'b0; e_fi = '0; e_vec = '0; ph = 0; pos = 0;
      if (k >= 1 && k < FIN_K) begin
        ph = (k-1) / PLEN; pos = (k-1) % PLEN;
        e_busy = 1'b1; e_fi = fi_of(ph); e_clr = (pos == 0);
        if (pos >= 1 && pos <= NV) e_vec = lfsr_seq[pos-1];
      end else if (k == FIN_K) e_done = 1'b1;

      chk("left_out",     left_out,     e_vec);
      chk("top_out",      top_out,      rev16(e_vec));
      chk("busy",         busy,         e_busy);
      chk("test_mode",    test_mode,    e_busy);
      chk("done",         done,         e_done);
      chk("pe_clr",       pe_clr,       e_clr);
      chk("fault_inject", fault_inject, e_fi);
      chk("pass",         pass,         e_pass);
      chk("fail_cnt",     fail_cnt,     e_fcnt);
      chk("fail_phase",   fail_phase,   e_fph);
      chk("static_sels",  {fsm_op2_sel, fsm_out_sel, stat_bit}, 3'b000);

      if (k == 2) begin cap_l0 = left_out; cap_t0 = top_out; end
      if (k == 3) cap_l1 = left_out;
      if (k >= 1 && k < FIN_K && pos == 0) fi_seen[ph] = fault_inject;

      if (!rst) k = 0;
      else if (k == 0) begin
        if (start) begin k = 1; e_fcnt = '0; e_fph = '0; e_pass = 1'b0; end
      end else if (k == FIN_K) k = 0;
      else begin
        if (pos == 0) misr_m = '0;
        else if (pos <= NV + PLT)
          misr_m = {misr_m[30:0], misr_m[31]} ^ {pe_bottom_in, pe_right_in} ^ (misr_m[31] ? POLY : 32'h0);
        else begin
          if (ph == 0) golden_m = misr_m;
          else begin
            bad = (ph == 7) ? (misr_m == golden_m) : (misr_m != golden_m);
            if (bad) begin
              if (e_fcnt != 3'd7) e_fcnt = e_fcnt + 3'd1;
              if (e_fph == 3'd0)  e_fph  = 3'(ph);
            end
          end
          if (ph == NPH-1) e_pass = (e_fcnt == 3'd0);
        end
        k++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk); cyc++;
      if (done === 1'b1) break;
      if (cyc > 2000) begin
        checks++; errors++;
        $display("FAIL wait_done: no done after %0d cycles", cyc);
        break;
      end
    end
  endtask

  task automatic rand_run(input int spam_pct, input bit fin_start);
    int cyc = 0;
    pulse_start();
    forever begin
      if (done === 1'b1) begin
        if (fin_start) begin start = 1'b1; @(posedge clk); #2 start = 1'b0; end
        break;
      end
      if (cyc > 2000) begin
        checks++; errors++;
        $display("FAIL rand_run: no done after %0d cycles", cyc);
        break;
      end
      start = ($urandom_range(99) < spam_pct);
      @(posedge clk); #2; cyc++;
    end
    start = 1'b0;
  endtask

  logic [5:0] fi_tab [8] = '{6'h00, 6'h01, 6'h03, 6'h04, 6'h0C, 6'h10, 6'h30, 6'h0F};

  initial begin : stim
    int lat;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fi",   fault_inject, 6'h00);
    chk("rst_left", left_out, 16'h0000);
    chk("rst_fcnt", fail_cnt, 3'd0);
    @(posedge clk); #2 rst = 1'b1;

    // healthy PE: full run, latency, LFSR pins, fault_inject table
    pe_mode = PE_OK;
    pulse_start(); wait_done(lat);
    chk("healthy_latency", lat, EXP_LAT);
    chk("healthy_pass", pass, 1'b1);
    chk("healthy_fail_cnt", fail_cnt, 3'd0);
    chk("healthy_fail_phase", fail_phase, 3'd0);
    chk("lfsr_vec0_left", cap_l0, 16'hACE1);
    chk("lfsr_vec1_left", cap_l1, 16'h5670);
    chk("lfsr_vec0_top",  cap_t0, 16'h8735);
    for (int p = 0; p < NPH; p++) chk($sformatf("fi_phase%0d", p), fi_seen[p], fi_tab[p]);

    // voter replaced by MAC0 pass-through
    @(posedge clk); #2 pe_mode = PE_MAC0;
    pulse_start(); wait_done(lat);
    chk("mac0_pass", pass, 1'b0);
    chk("mac0_fail_phase_1or2", (fail_phase == 3'd1 || fail_phase == 3'd2), 1'b1);
    chk("mac0_fail_cnt_ge1", (fail_cnt >= 3'd1), 1'b1);

    // right output stuck at zero: masking leaves pass high
    @(posedge clk); #2 pe_mode = PE_RZERO;
    pulse_start(); wait_done(lat);
    chk("rzero_pass", pass, 1'b1);

    // reset mid-APPLY of phase 3, then a full clean run
    @(posedge clk); #2 pe_mode = PE_OK;
    pulse_start();
    repeat (3*PLEN + 5) @(posedge clk);
    #2 rst = 1'b0; #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_fi",   fault_inject, 6'h00);
    chk("midrst_left", left_out, 16'h0000);
    chk("midrst_done", done, 1'b0);
    chk("midrst_pass", pass, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    pulse_start(); wait_done(lat);
    chk("postrst_latency", lat, EXP_LAT);
    chk("postrst_pass", pass, 1'b1);

    // random PE behaviour, start spam while busy, start coinciding with FIN
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #2 pe_mode = pe_mode_e'($urandom_range(3));
      repeat ($urandom_range(4)) @(posedge clk);
      rand_run(int'($urandom_range(30)), bit'($urandom_range(1)));
      repeat (3) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
